// File: rtl/oc8051_uart_txsched_pkg.sv
// Shared definitions for the OC8051 UART transmit scheduler: FSM encoding and SFR addresses.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package oc8051_uart_txsched_pkg;

  // SFR map entries used by the scheduler (OC8051 SFR space)
  localparam logic [7:0] SFR_SCON_ADDR   = 8'h98;
  localparam logic [7:0] SFR_SBUF_ADDR   = 8'h99;
  // Bit address of SCON.TI (SCON base 0x98, bit 1)
  localparam logic [7:0] SFR_SCON_TI_BIT = 8'h99;

  // Default TI wait limit in clk cycles when the timeout option is built in
  localparam logic [15:0] TO_CYCLES_DEFAULT = 16'd4096;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRECLR  = 3'd1,
    ST_WRITE   = 3'd2,
    ST_WAIT_TI = 3'd3,
    ST_CLEAR   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/oc8051_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves only when a grant is accepted.
// Latency: grants are combinational from the requests; the pointer updates on the accepting edge.
// Backpressure: none internally; the parent qualifies the grants and reports acceptance.
module oc8051_rr_arb2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  input  logic accept_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // 1 = requester 1 has priority on a tie; reset favours requester 0
  logic prio1_q;
  logic prio1_d;

  assign gnt0_o = req0_i & (~req1_i | ~prio1_q);
  assign gnt1_o = req1_i & (~req0_i |  prio1_q);

  // After an accept the winner loses priority to the other requester
  always_comb begin
    prio1_d = prio1_q;
    if (accept_i) prio1_d = gnt0_o;
  end

  // Priority pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prio1_q <= 1'b0;
    else         prio1_q <= prio1_d;
  end

endmodule

// File: rtl/oc8051_uart_txsched.sv
// Schedules bytes from two requesters onto the OC8051 SFR write bus toward the UART (SBUF write, TI handshake).
// Latency: accept at T, SBUF write at T+1 (T+2 with pre-clear); TI clear one cycle after TI is sampled high.
// Backpressure: ready only in IDLE; bus_busy stalls any pending SFR write. Option macro: OC8051_UART_TXSCHED_TIMEOUT_EN.
module oc8051_uart_txsched
  import oc8051_uart_txsched_pkg::*;
#(
  parameter logic [15:0] TO_CYCLES = TO_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       ti,
  input  logic       bus_busy,
  output logic       wr,
  output logic       wr_bit,
  output logic [7:0] wr_addr,
  output logic [7:0] data_in,
  output logic       bit_in,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic       err
);

  tx_state_e  state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       id_q, id_d;
  logic       gnt0, gnt1;
  logic       accept;

`ifdef OC8051_UART_TXSCHED_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        to_q, to_d;
`endif

  oc8051_rr_arb2 u_arb (
    .clk_i    (clk),
    .rst_ni   (rst),
    .req0_i   (req0_valid),
    .req1_i   (req1_valid),
    .accept_i (accept),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1)
  );

  // Ready is gated by reset so every output is low while rst is asserted
  assign req0_ready = rst & (state_q == ST_IDLE) & gnt0;
  assign req1_ready = rst & (state_q == ST_IDLE) & gnt1;
  assign accept     = (req0_ready & req0_valid) | (req1_ready & req1_valid);
  assign busy       = (state_q != ST_IDLE);

  // Next state, SFR bus drive and completion pulses; bus fields are only non-zero when a write issues
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    wr      = 1'b0;
    wr_bit  = 1'b0;
    wr_addr = 8'h00;
    data_in = 8'h00;
    bit_in  = 1'b0;
    done    = 1'b0;
    done_id = 1'b0;
    err     = 1'b0;
`ifdef OC8051_UART_TXSCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = req1_ready ? req1_data : req0_data;
          id_d    = req1_ready;
          // A stale TI from an earlier byte must be cleared before SBUF is loaded
          state_d = ti ? ST_PRECLR : ST_WRITE;
`ifdef OC8051_UART_TXSCHED_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end
      ST_PRECLR: begin
        if (!bus_busy) begin
          wr      = 1'b1;
          wr_bit  = 1'b1;
          wr_addr = SFR_SCON_TI_BIT;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!bus_busy) begin
          wr      = 1'b1;
          wr_addr = SFR_SBUF_ADDR;
          data_in = data_q;
          state_d = ST_WAIT_TI;
`ifdef OC8051_UART_TXSCHED_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      ST_WAIT_TI: begin
        if (ti) begin
          state_d = ST_CLEAR;
`ifdef OC8051_UART_TXSCHED_TIMEOUT_EN
        end else if (cnt_q == TO_CYCLES - 16'd1) begin
          // Give up on the UART: flag it and still clear TI so the next byte starts clean
          err     = 1'b1;
          to_d    = 1'b1;
          state_d = ST_CLEAR;
        end else begin
          cnt_d   = cnt_q + 16'd1;
`endif
        end
      end
      ST_CLEAR: begin
        if (!bus_busy) begin
          wr      = 1'b1;
          wr_bit  = 1'b1;
          wr_addr = SFR_SCON_TI_BIT;
          state_d = ST_IDLE;
`ifdef OC8051_UART_TXSCHED_TIMEOUT_EN
          done    = ~to_q;
`else
          done    = 1'b1;
`endif
          done_id = done & id_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and latched transfer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      data_q  <= 8'h00;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

`ifdef OC8051_UART_TXSCHED_TIMEOUT_EN
  // TI wait counter and timeout marker
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'd0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
`endif

endmodule

// File: tb/tb_oc8051_uart_txsched.sv
// Directed self-checking bench for oc8051_uart_txsched.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The timeout scenario is built only when OC8051_UART_TXSCHED_TIMEOUT_EN is defined.
module tb_oc8051_uart_txsched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic       ti = 1'b0, bus_busy = 1'b0;
  logic       wr, wr_bit, bit_in, busy, done, done_id, err;
  logic [7:0] wr_addr, data_in;
  logic [18:0] bus;

  int checks = 0;
  int errors = 0;

  localparam logic [18:0] BUS_IDLE = 19'd0;
  localparam logic [18:0] BUS_TICLR = {1'b1, 1'b1, 1'b0, 8'h99, 8'h00};

  oc8051_uart_txsched #(.TO_CYCLES(16'd16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .ti(ti), .bus_busy(bus_busy),
    .wr(wr), .wr_bit(wr_bit), .wr_addr(wr_addr), .data_in(data_in), .bit_in(bit_in),
    .busy(busy), .done(done), .done_id(done_id), .err(err)
  );

  always #5 clk = ~clk;

  assign bus = {wr, wr_bit, bit_in, wr_addr, data_in};

  function automatic logic [18:0] bus_sbuf(input logic [7:0] d);
    return {1'b1, 1'b0, 1'b0, 8'h99, d};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; ti = 1'b0; bus_busy = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #3;
    checks++;
    if ({req0_ready, req1_ready, busy, done, done_id, err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp %b", {req0_ready, req1_ready, busy, done, done_id, err}, 6'b0);
    end
    checks++;
    if (bus !== BUS_IDLE) begin errors++; $display("FAIL reset_bus got %h exp %h", bus, BUS_IDLE); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    sample();
    checks++;
    if ({busy, bus} !== 20'd0) begin errors++; $display("FAIL reset_idle got %h exp %h", {busy, bus}, 20'd0); end
  endtask

  task automatic test_basic();
    tick(); req0_valid = 1'b1; req0_data = 8'hA5; ti = 1'b0;
    sample();
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL basic_ready got %b exp %b", {req0_ready, req1_ready}, 2'b10); end
    tick(); req0_valid = 1'b0;
    sample();
    checks++;
    if ({busy, bus} !== {1'b1, bus_sbuf(8'hA5)}) begin errors++; $display("FAIL basic_write got %h exp %h", {busy, bus}, {1'b1, bus_sbuf(8'hA5)}); end
    for (int i = 0; i < 9; i++) begin
      tick(); sample();
      checks++;
      if ({wr, done, busy} !== 3'b001) begin errors++; $display("FAIL basic_wait%0d got %b exp %b", i, {wr, done, busy}, 3'b001); end
    end
    tick(); ti = 1'b1;
    sample();
    checks++;
    if ({wr, done} !== 2'b00) begin errors++; $display("FAIL basic_ti_cycle got %b exp %b", {wr, done}, 2'b00); end
    tick(); ti = 1'b0;
    sample();
    checks++;
    if (bus !== BUS_TICLR) begin errors++; $display("FAIL basic_clear_bus got %h exp %h", bus, BUS_TICLR); end
    checks++;
    if ({done, done_id} !== 2'b10) begin errors++; $display("FAIL basic_done got %b exp %b", {done, done_id}, 2'b10); end
    tick(); sample();
    checks++;
    if ({busy, done, wr} !== 3'b000) begin errors++; $display("FAIL basic_back_idle got %b exp %b", {busy, done, wr}, 3'b000); end
  endtask

  task automatic test_back_to_back();
    logic exp_id;
    do_reset();
    tick(); req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h10; req1_data = 8'h21;
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 1);
      sample();
      checks++;
      if ({req0_ready, req1_ready} !== (exp_id ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL b2b_grant%0d got %b exp %b", k, {req0_ready, req1_ready}, (exp_id ? 2'b01 : 2'b10));
      end
      tick(); sample();
      checks++;
      if (bus !== bus_sbuf(exp_id ? 8'h21 : 8'h10)) begin
        errors++; $display("FAIL b2b_data%0d got %h exp %h", k, bus, bus_sbuf(exp_id ? 8'h21 : 8'h10));
      end
      tick();
      tick(); ti = 1'b1;
      tick(); ti = 1'b0;
      sample();
      checks++;
      if ({done, done_id} !== {1'b1, exp_id}) begin errors++; $display("FAIL b2b_done%0d got %b exp %b", k, {done, done_id}, {1'b1, exp_id}); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_preclr();
    tick(); req0_valid = 1'b1; req0_data = 8'h3C; ti = 1'b1;
    sample();
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL preclr_ready got %b exp %b", {req0_ready, req1_ready}, 2'b10); end
    tick(); req0_valid = 1'b0;
    sample();
    checks++;
    if (bus !== BUS_TICLR) begin errors++; $display("FAIL preclr_bitwr got %h exp %h", bus, BUS_TICLR); end
    tick(); ti = 1'b0;
    sample();
    checks++;
    if (bus !== bus_sbuf(8'h3C)) begin errors++; $display("FAIL preclr_sbuf got %h exp %h", bus, bus_sbuf(8'h3C)); end
    tick(); sample();
    checks++;
    if (wr !== 1'b0) begin errors++; $display("FAIL preclr_wait got %b exp %b", wr, 1'b0); end
    tick(); ti = 1'b1;
    tick(); ti = 1'b0;
    sample();
    checks++;
    if ({done, done_id} !== 2'b10) begin errors++; $display("FAIL preclr_done got %b exp %b", {done, done_id}, 2'b10); end
    tick();
  endtask

  task automatic test_bus_busy();
    req1_valid = 1'b1; req1_data = 8'h5A;
    sample();
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL busy_ready got %b exp %b", {req0_ready, req1_ready}, 2'b01); end
    tick(); req1_valid = 1'b0; bus_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      sample();
      checks++;
      if ({wr, busy} !== 2'b01) begin errors++; $display("FAIL busy_hold%0d got %b exp %b", i, {wr, busy}, 2'b01); end
    end
    tick(); bus_busy = 1'b0;
    sample();
    checks++;
    if (bus !== bus_sbuf(8'h5A)) begin errors++; $display("FAIL busy_release got %h exp %h", bus, bus_sbuf(8'h5A)); end
    tick(); sample();
    checks++;
    if (wr !== 1'b0) begin errors++; $display("FAIL busy_single_write got %b exp %b", wr, 1'b0); end
    tick(); ti = 1'b1;
    tick(); ti = 1'b0;
    sample();
    checks++;
    if ({done, done_id} !== 2'b11) begin errors++; $display("FAIL busy_done got %b exp %b", {done, done_id}, 2'b11); end
    tick();
  endtask

`ifdef OC8051_UART_TXSCHED_TIMEOUT_EN
  task automatic test_timeout();
    req0_valid = 1'b1; req0_data = 8'h77;
    sample();
    tick(); req0_valid = 1'b0;
    sample();
    checks++;
    if (bus !== bus_sbuf(8'h77)) begin errors++; $display("FAIL to_write got %h exp %h", bus, bus_sbuf(8'h77)); end
    for (int i = 0; i < 15; i++) begin
      tick(); sample();
      checks++;
      if ({err, wr} !== 2'b00) begin errors++; $display("FAIL to_early%0d got %b exp %b", i, {err, wr}, 2'b00); end
    end
    tick(); sample();
    checks++;
    if ({err, done} !== 2'b10) begin errors++; $display("FAIL to_err got %b exp %b", {err, done}, 2'b10); end
    tick(); sample();
    checks++;
    if ({bus, done, err} !== {BUS_TICLR, 2'b00}) begin errors++; $display("FAIL to_clear got %h exp %h", {bus, done, err}, {BUS_TICLR, 2'b00}); end
    tick(); sample();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL to_idle got %b exp %b", busy, 1'b0); end
  endtask
`else
  task automatic test_no_timeout();
    req0_valid = 1'b1; req0_data = 8'h77;
    sample();
    tick(); req0_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(); sample();
      checks++;
      if ({err, busy, wr} !== 3'b010) begin errors++; $display("FAIL nto_wait%0d got %b exp %b", i, {err, busy, wr}, 3'b010); end
    end
    tick(); ti = 1'b1;
    tick(); ti = 1'b0;
    sample();
    checks++;
    if ({done, done_id, err} !== 3'b100) begin errors++; $display("FAIL nto_done got %b exp %b", {done, done_id, err}, 3'b100); end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_data = 8'h42;
    sample();
    tick(); req0_valid = 1'b0;
    tick();
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h43; rst = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, busy, done, err} !== 5'b0) begin
      errors++; $display("FAIL rstmid_ctrl got %b exp %b", {req0_ready, req1_ready, busy, done, err}, 5'b0);
    end
    checks++;
    if (bus !== BUS_IDLE) begin errors++; $display("FAIL rstmid_bus got %h exp %h", bus, BUS_IDLE); end
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, busy} !== 3'b100) begin errors++; $display("FAIL rstmid_grant got %b exp %b", {req0_ready, req1_ready, busy}, 3'b100); end
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;
    sample();
    checks++;
    if ({done, bus} !== {1'b0, bus_sbuf(8'h43)}) begin errors++; $display("FAIL rstmid_new got %h exp %h", {done, bus}, {1'b0, bus_sbuf(8'h43)}); end
    tick(); ti = 1'b1;
    tick(); ti = 1'b0;
    sample();
    checks++;
    if ({done, done_id} !== 2'b10) begin errors++; $display("FAIL rstmid_done got %b exp %b", {done, done_id}, 2'b10); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_preclr();
    test_bus_busy();
`ifdef OC8051_UART_TXSCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
